// File: rtl/mfp_line_drawer_pkg.sv
// Shared definitions for the Bresenham line engine.
//   COORD_W_DEF : default coordinate width (unsigned screen coordinates)
//   ERR_W_DEF   : default signed error-accumulator width (>= COORD_W + 3)
//   ld_state_t  : line-engine FSM state encoding (2-bit)
package mfp_line_drawer_pkg;

   localparam int COORD_W_DEF = 13;
   localparam int ERR_W_DEF   = 16;

   typedef enum logic [1:0] {
      LD_IDLE  = 2'd0,
      LD_SETUP = 2'd1,
      LD_DRAW  = 2'd2,
      LD_DONE  = 2'd3
   } ld_state_t;

endpackage

// File: rtl/mfp_line_drawer_if.sv
// Register and pixel-stream bundle of the line engine.
//   IO_LINE_DRAWING_X0/Y0/X1/Y1 : endpoint coordinates from software
//   IO_LINE_DRAWING_START       : level; a rising edge launches a line
//   IO_LINE_DRAWING_RESET       : level-sensitive soft reset
//   IO_LINE_DRAWING_FINISH      : sticky done flag
//   PIX_X/PIX_Y/PIX_VALID       : pixel stream toward the framebuffer writer
//   PIX_READY                   : framebuffer accepts the pixel this cycle
// master = software/framebuffer side, slave = line engine.
interface mfp_line_drawer_if #(
   parameter int COORD_W = 13
);
   logic [COORD_W-1:0] IO_LINE_DRAWING_X0;
   logic [COORD_W-1:0] IO_LINE_DRAWING_Y0;
   logic [COORD_W-1:0] IO_LINE_DRAWING_X1;
   logic [COORD_W-1:0] IO_LINE_DRAWING_Y1;
   logic               IO_LINE_DRAWING_START;
   logic               IO_LINE_DRAWING_RESET;
   logic               IO_LINE_DRAWING_FINISH;
   logic [COORD_W-1:0] PIX_X;
   logic [COORD_W-1:0] PIX_Y;
   logic               PIX_VALID;
   logic               PIX_READY;

   modport master (
      output IO_LINE_DRAWING_X0, IO_LINE_DRAWING_Y0,
      output IO_LINE_DRAWING_X1, IO_LINE_DRAWING_Y1,
      output IO_LINE_DRAWING_START, IO_LINE_DRAWING_RESET,
      output PIX_READY,
      input  IO_LINE_DRAWING_FINISH, PIX_X, PIX_Y, PIX_VALID
   );

   modport slave (
      input  IO_LINE_DRAWING_X0, IO_LINE_DRAWING_Y0,
      input  IO_LINE_DRAWING_X1, IO_LINE_DRAWING_Y1,
      input  IO_LINE_DRAWING_START, IO_LINE_DRAWING_RESET,
      input  PIX_READY,
      output IO_LINE_DRAWING_FINISH, PIX_X, PIX_Y, PIX_VALID
   );

endinterface

// File: rtl/mfp_line_step.sv
// One Bresenham step, purely combinational.
//   err, dx, dy      : signed accumulator state (dx >= 0, dy <= 0)
//   sx_neg, sy_neg   : 1 = step towards smaller coordinate
//   cur_x, cur_y     : current pixel
//   nxt_x, nxt_y     : pixel after this step
//   nxt_err          : accumulator after this step
module mfp_line_step #(
   parameter int COORD_W = 13,
   parameter int ERR_W   = 16
) (
   input  logic signed [ERR_W-1:0]   err,
   input  logic signed [ERR_W-1:0]   dx,
   input  logic signed [ERR_W-1:0]   dy,
   input  logic                      sx_neg,
   input  logic                      sy_neg,
   input  logic        [COORD_W-1:0] cur_x,
   input  logic        [COORD_W-1:0] cur_y,
   output logic        [COORD_W-1:0] nxt_x,
   output logic        [COORD_W-1:0] nxt_y,
   output logic signed [ERR_W-1:0]   nxt_err
);

   localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

   logic signed [ERR_W-1:0] e2;
   logic                    step_x;
   logic                    step_y;

   // Both compares use the pre-update err; a diagonal step applies dx+dy at once.
   always_comb begin
      e2      = err <<< 1;
      step_x  = (e2 >= dy);
      step_y  = (e2 <= dx);
      nxt_x   = cur_x;
      nxt_y   = cur_y;
      nxt_err = err;
      if (step_x) begin
         nxt_x   = sx_neg ? (cur_x - ONE) : (cur_x + ONE);
         nxt_err = nxt_err + dy;
      end
      if (step_y) begin
         nxt_y   = sy_neg ? (cur_y - ONE) : (cur_y + ONE);
         nxt_err = nxt_err + dx;
      end
   end

endmodule

// File: rtl/mfp_line_drawer.sv
// Bresenham line engine: latches endpoints on a START rising edge and emits
// one pixel per accepted valid/ready beat, then raises a sticky FINISH.
//   HCLK   : system clock
//   HRESET : synchronous active-high reset
//   bus    : register/pixel bundle (slave side), see mfp_line_drawer_if
//
// state    | meaning
// ---------+-------------------------------------------------------------
// LD_IDLE  | waiting for a START rising edge; endpoints latched on launch
// LD_SETUP | compute dx, dy, step signs, initial err; load first pixel
// LD_DRAW  | PIX_VALID=1; advance one Bresenham step per accepted beat
// LD_DONE  | one cycle with PIX_VALID=0; sets FINISH on exit
module mfp_line_drawer
   import mfp_line_drawer_pkg::*;
#(
   parameter int COORD_W = COORD_W_DEF,
   parameter int ERR_W   = ERR_W_DEF
) (
   input  logic             HCLK,
   input  logic             HRESET,
   mfp_line_drawer_if.slave bus
);

   localparam int PAD = ERR_W - COORD_W;

   ld_state_t state;
   ld_state_t state_nxt;

   logic                    clr;
   logic                    start_d;
   logic                    launch;
   logic                    finish;
   logic                    pix_valid;
   logic                    at_end;
   logic                    beat;

   logic [COORD_W-1:0]      x0_r, y0_r, x1_r, y1_r;
   logic [COORD_W-1:0]      cur_x, cur_y;
   logic [COORD_W-1:0]      nxt_x, nxt_y;
   logic signed [ERR_W-1:0] dx, dy, err, nxt_err;
   logic signed [ERR_W-1:0] x0_e, y0_e, x1_e, y1_e;
   logic signed [ERR_W-1:0] dx_set, dy_set;
   logic                    sx_neg, sy_neg;

   assign clr    = HRESET | bus.IO_LINE_DRAWING_RESET;
   assign launch = bus.IO_LINE_DRAWING_START & ~start_d;
   assign at_end = (cur_x == x1_r) && (cur_y == y1_r);
   assign beat   = (state == LD_DRAW) && bus.PIX_READY;

   assign x0_e = $signed({{PAD{1'b0}}, x0_r});
   assign y0_e = $signed({{PAD{1'b0}}, y0_r});
   assign x1_e = $signed({{PAD{1'b0}}, x1_r});
   assign y1_e = $signed({{PAD{1'b0}}, y1_r});

   // dx is |x1-x0|, dy is -|y1-y0|
   always_comb begin
      dx_set = (x1_e >= x0_e) ? (x1_e - x0_e) : (x0_e - x1_e);
      dy_set = (y1_e >= y0_e) ? (y0_e - y1_e) : (y1_e - y0_e);
   end

   mfp_line_step #(
      .COORD_W (COORD_W),
      .ERR_W   (ERR_W)
   ) u_step (
      .err     (err),
      .dx      (dx),
      .dy      (dy),
      .sx_neg  (sx_neg),
      .sy_neg  (sy_neg),
      .cur_x   (cur_x),
      .cur_y   (cur_y),
      .nxt_x   (nxt_x),
      .nxt_y   (nxt_y),
      .nxt_err (nxt_err)
   );

   always_ff @(posedge HCLK) begin
      if (clr) state <= LD_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pix_valid = 1'b0;
      case (state)
         LD_IDLE:  if (launch) state_nxt = LD_SETUP;
         LD_SETUP: state_nxt = LD_DRAW;
         LD_DRAW: begin
            pix_valid = 1'b1;
            if (bus.PIX_READY && at_end) state_nxt = LD_DONE;
         end
         LD_DONE:  state_nxt = LD_IDLE;
         default:  state_nxt = LD_IDLE;
      endcase
   end

   // Control and visible outputs: cleared by either reset.
   always_ff @(posedge HCLK) begin
      if (clr) begin
         start_d <= 1'b0;
         finish  <= 1'b0;
         cur_x   <= '0;
         cur_y   <= '0;
      end else begin
         start_d <= bus.IO_LINE_DRAWING_START;
         if (state == LD_IDLE && launch) finish <= 1'b0;
         if (state == LD_DONE)           finish <= 1'b1;
         // cur only moves on entry to DRAW and on non-final beats, so the
         // pixel outputs hold their last value in every other state.
         if (state == LD_SETUP) begin
            cur_x <= x0_r;
            cur_y <= y0_r;
         end else if (beat && !at_end) begin
            cur_x <= nxt_x;
            cur_y <= nxt_y;
         end
      end
   end

   // Datapath registers: only meaningful once a line is launched.
   always_ff @(posedge HCLK) begin
      if (state == LD_IDLE && launch) begin
         x0_r <= bus.IO_LINE_DRAWING_X0;
         y0_r <= bus.IO_LINE_DRAWING_Y0;
         x1_r <= bus.IO_LINE_DRAWING_X1;
         y1_r <= bus.IO_LINE_DRAWING_Y1;
      end
      if (state == LD_SETUP) begin
         dx     <= dx_set;
         dy     <= dy_set;
         err    <= dx_set + dy_set;
         sx_neg <= !(x0_r < x1_r);
         sy_neg <= !(y0_r < y1_r);
      end else if (beat && !at_end) begin
         err <= nxt_err;
      end
   end

   assign bus.PIX_X                  = cur_x;
   assign bus.PIX_Y                  = cur_y;
   assign bus.PIX_VALID              = pix_valid;
   assign bus.IO_LINE_DRAWING_FINISH = finish;

endmodule

// File: tb/tb_mfp_line_drawer.sv
module tb_mfp_line_drawer;

   localparam int CW = 13;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;

   int exp_x[$];
   int exp_y[$];

   mfp_line_drawer_if #(.COORD_W(CW)) bus ();

   mfp_line_drawer #(
      .COORD_W (CW),
      .ERR_W   (16)
   ) dut (
      .HCLK   (clk),
      .HRESET (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Reference pixel list from the integer Bresenham rules.
   function automatic void ref_line(input int x0, input int y0, input int x1, input int y1);
      int x, y, dx, dy, sx, sy, err, e2;
      exp_x.delete();
      exp_y.delete();
      x  = x0;  y  = y0;
      dx = iabs(x1 - x0);
      dy = -iabs(y1 - y0);
      sx = (x0 < x1) ? 1 : -1;
      sy = (y0 < y1) ? 1 : -1;
      err = dx + dy;
      forever begin
         exp_x.push_back(x);
         exp_y.push_back(y);
         if (x == x1 && y == y1) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; x += sx; end
         if (e2 <= dx) begin err += dx; y += sy; end
      end
   endfunction

   // rmode: 0 READY always 1, 1 READY 1,0,0 repeating, 2 random READY.
   // rehit: extra START rising edge in the middle of the line.
   task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                           input int rmode, input bit rehit);
      int  n, idx, first, extra, span;
      bit  stall, v, rdy;
      logic [CW-1:0] hx, hy;
      ref_line(x0, y0, x1, y1);
      n = exp_x.size();
      span = (iabs(x1 - x0) > iabs(y1 - y0)) ? iabs(x1 - x0) : iabs(y1 - y0);
      idx = 0; first = 0; stall = 1'b0; hx = '0; hy = '0;
      @(negedge clk);
      bus.IO_LINE_DRAWING_X0    = CW'(x0);
      bus.IO_LINE_DRAWING_Y0    = CW'(y0);
      bus.IO_LINE_DRAWING_X1    = CW'(x1);
      bus.IO_LINE_DRAWING_Y1    = CW'(y1);
      bus.IO_LINE_DRAWING_START = 1'b1;
      bus.PIX_READY             = 1'b1;
      for (int cyc = 1; cyc <= n * 8 + 20 && idx < n; cyc++) begin
         @(negedge clk);
         // endpoints scrambled after launch must not matter
         bus.IO_LINE_DRAWING_X0 = CW'($urandom);
         bus.IO_LINE_DRAWING_Y1 = CW'($urandom);
         v = bus.PIX_VALID;
         if (cyc == 1) begin
            chk("setup_valid", v, 0);
            chk("finish_clr", bus.IO_LINE_DRAWING_FINISH, 0);
         end
         if (v && first == 0) begin
            first = cyc;
            chk("latency", cyc, 2);
         end
         if (stall) begin
            chk("stall_valid", v, 1);
            chk("stall_x", bus.PIX_X, hx);
            chk("stall_y", bus.PIX_Y, hy);
         end
         if (rehit && cyc == 3) bus.IO_LINE_DRAWING_START = 1'b0;
         if (rehit && cyc == 4) bus.IO_LINE_DRAWING_START = 1'b1;
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = ((cyc - 2) % 3 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         bus.PIX_READY = rdy;
         if (v && rdy) begin
            chk("pix_x", bus.PIX_X, exp_x[idx]);
            chk("pix_y", bus.PIX_Y, exp_y[idx]);
            idx++;
         end
         stall = v && !rdy;
         hx = bus.PIX_X;
         hy = bus.PIX_Y;
      end
      chk("beats", idx, span + 1);
      @(negedge clk);
      bus.PIX_READY = 1'b1;
      chk("done_valid", bus.PIX_VALID, 0);
      @(negedge clk);
      chk("finish", bus.IO_LINE_DRAWING_FINISH, 1);
      chk("idle_valid", bus.PIX_VALID, 0);
      // START still high: must not relaunch
      extra = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.PIX_VALID) extra++;
      end
      chk("no_relaunch", extra, 0);
      chk("finish_hold", bus.IO_LINE_DRAWING_FINISH, 1);
      chk("hold_x", bus.PIX_X, exp_x[n-1]);
      bus.IO_LINE_DRAWING_START = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int beats, extra, bx, by;
      bus.IO_LINE_DRAWING_X0    = '0;
      bus.IO_LINE_DRAWING_Y0    = '0;
      bus.IO_LINE_DRAWING_X1    = '0;
      bus.IO_LINE_DRAWING_Y1    = '0;
      bus.IO_LINE_DRAWING_START = 1'b0;
      bus.IO_LINE_DRAWING_RESET = 1'b0;
      bus.PIX_READY             = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_valid", bus.PIX_VALID, 0);
      chk("rst_finish", bus.IO_LINE_DRAWING_FINISH, 0);
      chk("rst_x", bus.PIX_X, 0);
      chk("rst_y", bus.PIX_Y, 0);
      rst = 1'b0;
      @(negedge clk);

      run_line(0, 0, 4, 0, 0, 1'b0);
      run_line(10, 7, 7, 3, 0, 1'b0);
      run_line(5, 5, 5, 5, 0, 1'b0);
      run_line(0, 0, 6, 2, 1, 1'b0);
      run_line(0, 0, 9, 4, 0, 1'b1);
      run_line(3, 12, 3, 2, 2, 1'b1);

      // soft reset mid-line
      @(negedge clk);
      bus.IO_LINE_DRAWING_X0    = 13'd0;
      bus.IO_LINE_DRAWING_Y0    = 13'd0;
      bus.IO_LINE_DRAWING_X1    = 13'd20;
      bus.IO_LINE_DRAWING_Y1    = 13'd0;
      bus.IO_LINE_DRAWING_START = 1'b1;
      bus.PIX_READY             = 1'b1;
      beats = 0;
      for (int cyc = 0; cyc < 30 && beats < 3; cyc++) begin
         @(negedge clk);
         if (bus.PIX_VALID) beats++;
      end
      chk("abort_pre_beats", beats, 3);
      @(negedge clk);
      chk("abort_pix4_x", bus.PIX_X, 3);
      bus.IO_LINE_DRAWING_RESET = 1'b1;
      bus.IO_LINE_DRAWING_START = 1'b0;
      @(negedge clk);
      chk("abort_valid", bus.PIX_VALID, 0);
      chk("abort_finish", bus.IO_LINE_DRAWING_FINISH, 0);
      chk("abort_x", bus.PIX_X, 0);
      bus.IO_LINE_DRAWING_RESET = 1'b0;
      extra = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.PIX_VALID) extra++;
      end
      chk("abort_no_pix", extra, 0);
      run_line(2, 3, 8, 1, 0, 1'b0);

      // randomized lines, including the top of the coordinate range
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 2))
            0:       begin bx = 0;    by = 0;    end
            1:       begin bx = 8151; by = 8151; end
            default: begin bx = $urandom_range(0, 8000); by = $urandom_range(0, 8000); end
         endcase
         run_line(bx + $urandom_range(0, 40), by + $urandom_range(0, 40),
                  bx + $urandom_range(0, 40), by + $urandom_range(0, 40),
                  $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
